// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned MUL/DIV (one bit per cycle) and LUI execute stage with start/busy/done handshake.
// Define MULDIV_OVERFLOW_EN to add the flag_ovf output (upper product half non-zero).
module muldiv_unit #(
    parameter int L = 16,
    parameter int P = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [P:0]   alu_op,
    input  logic         use_imm,
    input  logic         lui,
    input  logic [L-1:0] rs1,
    input  logic [L-1:0] rs2,
    input  logic [L-1:0] imm,
    output logic         busy,
    output logic         done,
    output logic [L-1:0] result,
    output logic         flag_zero,
    output logic         flag_div0
`ifdef MULDIV_OVERFLOW_EN
    ,
    output logic         flag_ovf
`endif
);
    localparam int CW = $clog2(L);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2*L-1:0] acc, acc_nxt;
    logic [L-1:0] opnd, bsel, rem_nxt;
    logic [L:0] sum, sh;
    logic is_mul, quick, accept, pend, pend_lui, mul_q, ge;
    // LUI and divide-by-zero finish one edge after acceptance via pend, without ever raising busy
    always_comb begin
        bsel = use_imm ? imm : rs2;
        is_mul = alu_op[0];
        quick = lui || (!is_mul && bsel == '0);
        accept = start && state != RUN && !pend;
        state_nxt = pend ? DONE : accept ? (quick ? IDLE : RUN) :
                    state == RUN ? (cnt == '0 ? DONE : RUN) : IDLE;
        busy = state == RUN;
        done = state == DONE;
    end
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        sum = {1'b0, acc[2*L-1:L]} + (acc[0] ? {1'b0, opnd} : '0);
        sh = acc[2*L-1:L-1];
        ge = sh >= {1'b0, opnd};
        rem_nxt = ge ? sh[L-1:0] - opnd : sh[L-1:0];
        acc_nxt = mul_q ? {sum, acc[L-1:1]} : {rem_nxt, acc[L-2:0], ge};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            opnd <= '0;
            mul_q <= 1'b0;
            pend <= 1'b0;
            pend_lui <= 1'b0;
            result <= '0;
            flag_zero <= 1'b0;
            flag_div0 <= 1'b0;
`ifdef MULDIV_OVERFLOW_EN
            flag_ovf <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            pend <= accept && quick;
            if (accept) begin
                mul_q <= is_mul;
                pend_lui <= lui;
                cnt <= CW'(L-1);
                opnd <= lui ? {imm[L/2-1:0], {L/2{1'b0}}} : is_mul ? rs1 : bsel;
                acc <= {{L{1'b0}}, is_mul ? bsel : rs1};
            end else if (state == RUN) begin
                acc <= acc_nxt;
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    result <= acc_nxt[L-1:0];
                    flag_zero <= acc_nxt[L-1:0] == '0;
                    flag_div0 <= flag_div0 && mul_q;
`ifdef MULDIV_OVERFLOW_EN
                    flag_ovf <= mul_q && |acc_nxt[2*L-1:L];
`endif
                end
            end
            if (pend) begin
                result <= pend_lui ? opnd : '1;
                if (!pend_lui) begin
                    flag_div0 <= 1'b1;
                    flag_zero <= 1'b0;
`ifdef MULDIV_OVERFLOW_EN
                    flag_ovf <= 1'b0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst, start, use_imm, lui;
    logic [0:0] alu_op;
    logic [15:0] rs1, rs2, imm, result;
    logic busy, done, flag_zero, flag_div0;
`ifdef MULDIV_OVERFLOW_EN
    logic flag_ovf;
`endif
    int errors = 0;
    int checks = 0;
    logic exp_zero = 1'b0, exp_div0 = 1'b0, exp_ovf = 1'b0;
    logic [15:0] exp_res = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.L(16), .P(0)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .use_imm(use_imm), .lui(lui),
        .rs1(rs1), .rs2(rs2), .imm(imm), .busy(busy), .done(done), .result(result),
        .flag_zero(flag_zero), .flag_div0(flag_div0)
`ifdef MULDIV_OVERFLOW_EN
        , .flag_ovf(flag_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_zero"}, 32'(flag_zero), 32'(exp_zero));
        check({tag, "_div0"}, 32'(flag_div0), 32'(exp_div0));
`ifdef MULDIV_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(flag_ovf), 32'(exp_ovf));
`endif
    endtask

    // Issue one operation; b2b starts it in the DONE cycle of the previous one.
    task automatic op(input string tag, input bit m, input bit l, input bit ui,
                      input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] im, input bit b2b);
        logic [15:0] b;
        logic [31:0] p;
        bit q;
        int n, bc;
        if (!b2b) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 32'(done), 0);
        end
        alu_op = m; lui = l; use_imm = ui; rs1 = r1; rs2 = r2; imm = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs1 = 16'($urandom); rs2 = 16'($urandom); imm = 16'($urandom);
        alu_op = 1'($urandom); use_imm = 1'($urandom); lui = 1'($urandom);
        b = ui ? im : r2;
        q = l || (!m && b == 16'h0);
        if (l) begin
            exp_res = {im[7:0], 8'h00};
        end else if (m) begin
            p = r1 * b;
            exp_res = p[15:0];
            exp_zero = exp_res == 16'h0;
            exp_ovf = |p[31:16];
        end else if (b == 16'h0) begin
            exp_res = 16'hFFFF; exp_div0 = 1'b1; exp_zero = 1'b0; exp_ovf = 1'b0;
        end else begin
            exp_res = r1 / b; exp_zero = exp_res == 16'h0; exp_div0 = 1'b0; exp_ovf = 1'b0;
        end
        n = 0; bc = 0;
        while (!done && n < 40) begin
            bc += int'(busy);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, q ? 1 : 16);
        check({tag, "_busy_cycles"}, bc, q ? 0 : 16);
        check_outs(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] r1, r2, im;
        bit m, l, ui, b2b;
        int n;
        rst = 1'b1; start = 1'b0; alu_op = '0; use_imm = 1'b0; lui = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check_outs("reset");
        op("mul_3x5", 1, 0, 0, 16'd3, 16'd5, 16'h0, 0);
        op("muli_ovf", 1, 0, 1, 16'h0100, 16'h9999, 16'h0100, 0);
        op("div_100_7", 0, 0, 0, 16'd100, 16'd7, 16'h0, 0);
        op("div_9_3_b2b", 0, 0, 0, 16'd9, 16'd3, 16'h0, 1);
        op("div_by_0", 0, 0, 0, 16'h1234, 16'h0, 16'h0, 0);
        op("lui", 0, 1, 0, 16'h0, 16'h0, 16'h55AB, 0);
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom);
            l = $urandom_range(0, 5) == 0;
            ui = 1'($urandom);
            r1 = 16'($urandom) >> $urandom_range(0, 8);
            r2 = $urandom_range(0, 5) == 0 ? 16'h0 : 16'($urandom) >> $urandom_range(0, 15);
            im = $urandom_range(0, 5) == 0 ? 16'h0 : 16'($urandom) >> $urandom_range(0, 15);
            b2b = 1'($urandom);
            op("rand", m, l, ui, r1, r2, im, b2b);
        end
        // abort a DIV with reset after an ignored second start
        @(posedge clk); #1;
        alu_op = 1'b0; lui = 1'b0; use_imm = 1'b0; rs1 = 16'd100; rs2 = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; alu_op = 1'b1; rs1 = 16'd5; rs2 = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_still_busy", 32'(busy), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        exp_res = '0; exp_zero = 1'b0; exp_div0 = 1'b0; exp_ovf = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check_outs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        repeat (25) begin
            @(posedge clk); #1;
            n += int'(done);
        end
        check("abort_no_done", n, 0);
        op("mul_2x2", 1, 0, 0, 16'd2, 16'd2, 16'h0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
